// File: rtl/sram_bist_if.sv
// Word request bus between the BIST initiator (master) and the SRAM controller (slave).
interface sram_bist_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  o_en;
    logic                  o_rnw;
    logic [ADDR_WIDTH-1:0] o_address;
    logic [DATA_WIDTH-1:0] o_data_out;
    logic [DATA_WIDTH-1:0] i_data_in;
    logic                  i_data_valid;

    modport master (
        output o_en, o_rnw, o_address, o_data_out,
        input  i_data_in, i_data_valid
    );

    modport slave (
        input  o_en, o_rnw, o_address, o_data_out,
        output i_data_in, i_data_valid
    );
endinterface

// File: rtl/sram_bist.sv
// SRAM self-test initiator: full write pass of address^seed, then read-and-compare pass,
// with error count, first-failure capture and per-transaction handshake timeout.
module sram_bist #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
    parameter int                    NUM_WORDS  = 524288,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_seed,
    sram_bist_if.master           bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [15:0]           o_err_count,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr,
    output logic [DATA_WIDTH-1:0] o_first_err_data
);
    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  mismatch;
    logic [15:0]           err_next;

    assign word_addr = BASE_ADDR + (ADDR_WIDTH'(idx) << 2);
    assign pattern   = DATA_WIDTH'(word_addr) ^ seed_q;
    assign mismatch  = (bus.i_data_in != pattern);

    always_comb begin
        err_next = o_err_count;
        if (mismatch && (o_err_count != 16'hFFFF))
            err_next = o_err_count + 16'd1;
    end

    // Bus outputs decode only registered state/index, so no input reaches them combinationally.
    assign o_busy         = (state != IDLE) && (state != DONE);
    assign bus.o_en       = (state == WR_REQ) || (state == RD_REQ);
    assign bus.o_rnw      = (state == RD_REQ);
    assign bus.o_address  = o_busy ? word_addr : '0;
    assign bus.o_data_out = (state == WR_REQ) ? pattern : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= '0;
            wait_cnt         <= '0;
            seed_q           <= '0;
            o_done           <= 1'b0;
            o_pass           <= 1'b0;
            o_timeout        <= 1'b0;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
            o_first_err_data <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        seed_q           <= i_seed;
                        idx              <= '0;
                        wait_cnt         <= '0;
                        o_done           <= 1'b0;
                        o_pass           <= 1'b0;
                        o_timeout        <= 1'b0;
                        o_err_count      <= '0;
                        o_first_err_addr <= '0;
                        o_first_err_data <= '0;
                        state            <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    wait_cnt <= '0;
                    state    <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (bus.i_data_valid) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= RD_REQ;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= WR_REQ;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        o_timeout <= 1'b1;
                        o_pass    <= 1'b0;
                        o_done    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                RD_REQ: begin
                    wait_cnt <= '0;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (bus.i_data_valid) begin
                        o_err_count <= err_next;
                        if (mismatch && (o_err_count == '0)) begin
                            o_first_err_addr <= bus.o_address;
                            o_first_err_data <= bus.i_data_in;
                        end
                        if (idx == LAST_IDX) begin
                            o_pass <= (err_next == '0);
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= RD_REQ;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        o_timeout <= 1'b1;
                        o_pass    <= 1'b0;
                        o_done    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_bist.sv
// Directed bench for sram_bist: 8-word range, TIMEOUT=15, bench-side SRAM responder model.
module tb_sram_bist;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seed;
    logic          busy, done, pass, tmo;
    logic [15:0]   err_count;
    logic [AW-1:0] first_addr;
    logic [DW-1:0] first_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_bist #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BASE_ADDR (32'h8000_0000),
        .NUM_WORDS (NW),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (start),
        .i_seed          (seed),
        .bus             (bus),
        .o_busy          (busy),
        .o_done          (done),
        .o_pass          (pass),
        .o_timeout       (tmo),
        .o_err_count     (err_count),
        .o_first_err_addr(first_addr),
        .o_first_err_data(first_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic p, input logic t,
                                input logic [15:0] e, input logic [31:0] fa, input logic [31:0] fd);
        check({tag, "_done"}, done, d);
        check({tag, "_pass"}, pass, p);
        check({tag, "_timeout"}, tmo, t);
        check({tag, "_err_count"}, err_count, e);
        check({tag, "_first_addr"}, first_addr, fa);
        check({tag, "_first_data"}, first_data, fd);
    endtask

    // One BIST run from an accepted start in the current cycle (cycle 0). The responder answers
    // every request one cycle later, except write index 'hold'; read word 'stuck' gets bit 3 forced.
    task automatic run_bist(input logic [31:0] s, input int stuck, input int hold, input int mid,
                            input bit abort, output int done_cyc, output int nen,
                            output int extra_en, output logic [31:0] wdata0,
                            output logic [31:0] last_waddr);
        logic [31:0] mem [NW];
        logic [31:0] exp_addr;
        logic [31:0] pend_data;
        bit          pend;
        int          cyc;
        int          k;
        done_cyc   = -1;
        nen        = 0;
        extra_en   = 0;
        wdata0     = '0;
        last_waddr = '0;
        pend       = 1'b0;
        pend_data  = '0;
        cyc        = 0;
        start      = 1'b1;
        seed       = s;
        while (done_cyc < 0 && cyc < 120) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == mid);
            seed  = (cyc == mid) ? 32'hFFFF_FFFF : s;
            bus.i_data_valid = pend;
            bus.i_data_in    = pend ? pend_data : '0;
            pend = 1'b0;
            if (cyc == 1) begin
                check("started_busy", busy, 1'b1);
                check_status("started", 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
            end
            if (done) begin
                done_cyc = cyc;
            end else if (bus.o_en) begin
                k = nen;
                nen++;
                exp_addr = 32'h8000_0000 + 32'(4 * (k % NW));
                check("req_addr", bus.o_address, exp_addr);
                if (hold < 0) check("req_cycle", cyc, 1 + 2 * k);
                if (k < NW) begin
                    check("wr_rnw", bus.o_rnw, 1'b0);
                    check("wr_data", bus.o_data_out, exp_addr ^ s);
                    mem[k] = bus.o_data_out;
                    if (k == 0) wdata0 = bus.o_data_out;
                    last_waddr = bus.o_address;
                    pend = (k != hold);
                end else begin
                    check("rd_rnw", bus.o_rnw, 1'b1);
                    check("rd_data_out_zero", bus.o_data_out, 32'h0);
                    if (abort) begin
                        rst = 1'b1;
                        @(posedge clk); #1;
                        check("abort_en", bus.o_en, 1'b0);
                        check("abort_busy", busy, 1'b0);
                        rst = 1'b0;
                        start = 1'b0;
                        bus.i_data_valid = 1'b0;
                        return;
                    end
                    pend      = 1'b1;
                    pend_data = mem[k - NW] | ((k - NW == stuck) ? 32'h8 : 32'h0);
                end
            end
        end
        if (done_cyc < 0) check("done_within_budget", done, 1'b1);
        start = 1'b0;
        bus.i_data_valid = 1'b0;
        bus.i_data_in    = '0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.o_en) extra_en++;
        end
    endtask

    int          dcyc, nen, xen;
    logic [31:0] w0, lwa;

    initial begin
        rst = 1'b1;
        start = 1'b1;
        seed = 32'hDEAD_BEEF;
        bus.i_data_valid = 1'b0;
        bus.i_data_in = '0;

        // Reset held with start asserted: nothing may leave IDLE
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_en", bus.o_en, 1'b0);
            check("rst_busy", busy, 1'b0);
        end
        check("rst_rnw", bus.o_rnw, 1'b0);
        check("rst_addr", bus.o_address, 32'h0);
        check("rst_wdata", bus.o_data_out, 32'h0);
        check_status("rst", 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        // Clean run
        run_bist(32'hA5A5_A5A5, -1, -1, -1, 1'b0, dcyc, nen, xen, w0, lwa);
        check("clean_done_cycle", dcyc, 33);
        check("clean_req_count", nen, 16);
        check("clean_word0", w0, 32'h25A5_A5A5);
        check("clean_last_waddr", lwa, 32'h8000_001C);
        check("clean_busy_after", busy, 1'b0);
        check_status("clean", 1'b1, 1'b1, 1'b0, 16'h0, 32'h0, 32'h0);

        // Stuck-at-1 on bit 3 of word 5: 0x80000014^0xA5A5A5A5 = 0x25A5A5B1, reads 0x25A5A5B9
        run_bist(32'hA5A5_A5A5, 5, -1, -1, 1'b0, dcyc, nen, xen, w0, lwa);
        check("stuck_done_cycle", dcyc, 33);
        check_status("stuck", 1'b1, 1'b0, 1'b0, 16'h1, 32'h8000_0014, 32'h25A5_A5B9);

        // Write index 2 never acknowledged: its o_en is at cycle 5, DONE 16 cycles later
        run_bist(32'h1234_5678, -1, 2, -1, 1'b0, dcyc, nen, xen, w0, lwa);
        check("tmo_done_cycle", dcyc, 21);
        check("tmo_req_count", nen, 3);
        check("tmo_no_more_en", xen, 0);
        check_status("tmo", 1'b1, 1'b0, 1'b1, 16'h0, 32'h0, 32'h0);

        // Restart after failure, with a stray start during the read pass
        run_bist(32'h0F0F_0000, -1, -1, 20, 1'b0, dcyc, nen, xen, w0, lwa);
        check("rerun_done_cycle", dcyc, 33);
        check("rerun_req_count", nen, 16);
        check("rerun_word0", w0, 32'h8F0F_0000);
        check("rerun_no_more_en", xen, 0);
        check_status("rerun", 1'b1, 1'b1, 1'b0, 16'h0, 32'h0, 32'h0);

        // Reset at the first read request
        run_bist(32'h5555_AAAA, -1, -1, -1, 1'b1, dcyc, nen, xen, w0, lwa);
        check("abort_req_count", nen, 9);
        check_status("abort", 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
